// File: rtl/yari_mem_bridge_pkg.sv
// yari_mem_bridge_pkg: requester IDs, FSM states and return-tag type shared by the bridge
package yari_mem_bridge_pkg;
  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_DC   = 2'd1;
  localparam logic [1:0] ID_IC   = 2'd2;
  typedef enum logic {IDLE, BURST} state_e;
  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } ret_t;
endpackage

// File: rtl/yari_mem_retpipe.sv
// yari_mem_retpipe: LATENCY-deep valid+tag delay line tracking SRAM reads in flight
module yari_mem_retpipe
  import yari_mem_bridge_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic clock,
  input  logic rst,
  input  ret_t din,
  output ret_t dout
);
  ret_t [LATENCY-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clock) pipe_q <= rst ? '0 : pipe_d;
  assign dout = pipe_q[LATENCY-1];
endmodule

// File: rtl/yari_mem_bridge.sv
// yari_mem_bridge: tagged memory-port slave issuing wrapped read bursts and masked writes
// to a pipelined fixed-latency SRAM, returning read words tagged with the requester ID.
module yari_mem_bridge
  import yari_mem_bridge_pkg::*;
#(
  parameter int BURST_LG = 2,
  parameter int LATENCY  = 2
) (
  input  logic        clock,
  input  logic        rst,
  output logic        mem_waitrequest,
  input  logic [1:0]  mem_id,
  input  logic [29:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_writedata,
  input  logic [3:0]  mem_writedatamask,
  output logic [31:0] mem_readdata,
  output logic [1:0]  mem_readdataid,
  output logic [29:0] sram_addr,
  output logic        sram_rd,
  output logic        sram_wr,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_be,
  input  logic [31:0] sram_rdata
);
  localparam int CW = (BURST_LG > 0) ? BURST_LG : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << BURST_LG) - 1);
  localparam logic [29:0] LINE_MASK = 30'((1 << BURST_LG) - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0] base_q, base_d, waddr_q, waddr_d, burst_addr;
  logic [1:0]  id_q, id_d, rid_q, rid_d;
  logic        wr_q, wr_d, accept;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  ret_t        ret_in, ret_out;

  assign mem_waitrequest = rst | (state_q == BURST);
  assign accept = !mem_waitrequest & (mem_read | mem_write);
  // critical word first: only the in-line offset advances, wrapping inside the line
  assign burst_addr = (base_q & ~LINE_MASK) | ((base_q + 30'(cnt_q)) & LINE_MASK);
  assign sram_rd = (state_q == BURST);
  assign sram_addr = sram_rd ? burst_addr : waddr_q;
  assign sram_wr = wr_q;
  assign sram_wdata = wdata_q;
  assign sram_be = be_q;
  assign mem_readdata = rdata_q;
  assign mem_readdataid = rid_q;
  assign ret_in = '{valid: sram_rd, id: id_q};

  yari_mem_retpipe #(.LATENCY(LATENCY)) u_retpipe (
    .clock(clock),
    .rst  (rst),
    .din  (ret_in),
    .dout (ret_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    base_d = base_q;
    id_d = id_q;
    wr_d = accept & mem_write;
    waddr_d = wr_d ? mem_address : waddr_q;
    wdata_d = wr_d ? mem_writedata : wdata_q;
    be_d = wr_d ? mem_writedatamask : be_q;
    rdata_d = ret_out.valid ? sram_rdata : rdata_q;
    rid_d = ret_out.valid ? ret_out.id : ID_NONE;
    if (state_q == IDLE) begin
      if (accept & mem_read & !mem_write) begin
        state_d = BURST;
        base_d = mem_address;
        id_d = mem_id;
        cnt_d = '0;
      end
    end else begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      state_d = (cnt_q == LAST) ? IDLE : BURST;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      id_q <= ID_NONE;
      wr_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      rdata_q <= '0;
      rid_q <= ID_NONE;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      id_q <= id_d;
      wr_q <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      rdata_q <= rdata_d;
      rid_q <= rid_d;
    end
  end

`ifndef SYNTHESIS
  // a simultaneous read is dropped in favour of the write; flag it in simulation
  assert property (@(posedge clock) disable iff (rst) !(accept && mem_read && mem_write))
    else $error("yari_mem_bridge: mem_read and mem_write both high, read dropped");
`endif
endmodule

// File: tb/tb_yari_mem_bridge.sv
// tb_yari_mem_bridge: directed self-checking bench for yari_mem_bridge and two parameter corners
module tb_yari_mem_bridge;
  logic        clock, rst;
  logic        mem_waitrequest, mem_read, mem_write;
  logic [1:0]  mem_id, mem_readdataid;
  logic [29:0] mem_address, sram_addr;
  logic [31:0] mem_writedata, mem_readdata, sram_wdata, sram_rdata;
  logic [3:0]  mem_writedatamask, sram_be;
  logic        sram_rd, sram_wr;
  logic        s_read;
  logic [1:0]  s_id;
  logic [29:0] s_addr;
  logic        a_wait, a_rd, a_wr, b_wait, b_rd, b_wr;
  logic [1:0]  a_id, b_id;
  logic [29:0] a_sram_addr, b_sram_addr;
  logic [31:0] a_data, b_data, a_wdata, b_wdata, a_rdata, b_rdata;
  logic [3:0]  a_be, b_be;
  logic [31:0] mem [0:1023];
  logic [31:0] rp [0:1];
  logic [31:0] bp [0:7];
  int checks = 0;
  int errors = 0;

  yari_mem_bridge #(.BURST_LG(2), .LATENCY(2)) dut (
    .clock(clock), .rst(rst), .mem_waitrequest(mem_waitrequest), .mem_id(mem_id),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_writedatamask(mem_writedatamask),
    .mem_readdata(mem_readdata), .mem_readdataid(mem_readdataid), .sram_addr(sram_addr),
    .sram_rd(sram_rd), .sram_wr(sram_wr), .sram_wdata(sram_wdata), .sram_be(sram_be),
    .sram_rdata(sram_rdata));

  yari_mem_bridge #(.BURST_LG(0), .LATENCY(1)) dut_a (
    .clock(clock), .rst(rst), .mem_waitrequest(a_wait), .mem_id(s_id),
    .mem_address(s_addr), .mem_read(s_read), .mem_write(1'b0),
    .mem_writedata(32'h0), .mem_writedatamask(4'h0),
    .mem_readdata(a_data), .mem_readdataid(a_id), .sram_addr(a_sram_addr),
    .sram_rd(a_rd), .sram_wr(a_wr), .sram_wdata(a_wdata), .sram_be(a_be),
    .sram_rdata(a_rdata));

  yari_mem_bridge #(.BURST_LG(3), .LATENCY(8)) dut_b (
    .clock(clock), .rst(rst), .mem_waitrequest(b_wait), .mem_id(s_id),
    .mem_address(s_addr), .mem_read(s_read), .mem_write(1'b0),
    .mem_writedata(32'h0), .mem_writedatamask(4'h0),
    .mem_readdata(b_data), .mem_readdataid(b_id), .sram_addr(b_sram_addr),
    .sram_rd(b_rd), .sram_wr(b_wr), .sram_wdata(b_wdata), .sram_be(b_be),
    .sram_rdata(b_rdata));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // main SRAM model: latency 2, byte-masked writes, reads see contents before same-edge write
  always @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= (i == 64) ? 32'h11111111 : (32'hA5000000 | i);
    end else if (sram_wr) begin
      for (int j = 0; j < 4; j++)
        if (sram_be[j]) mem[sram_addr[9:0]][8*j +: 8] <= sram_wdata[8*j +: 8];
    end
    rp[0] <= mem[sram_addr[9:0]];
    rp[1] <= rp[0];
  end
  assign sram_rdata = rp[1];

  // corner SRAMs return the word address as data
  always @(posedge clock) a_rdata <= {2'b0, a_sram_addr};
  always @(posedge clock) begin
    bp[0] <= {2'b0, b_sram_addr};
    for (int i = 1; i < 8; i++) bp[i] <= bp[i-1];
  end
  assign b_rdata = bp[7];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    checks++; if (mem_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait got=%0b exp=1", mem_waitrequest); end
    tick;
    checks++; if (sram_rd !== 1'b0 || sram_wr !== 1'b0) begin errors++; $display("FAIL reset_strobes got rd=%0b wr=%0b exp 0 0", sram_rd, sram_wr); end
    checks++; if (mem_readdataid !== 2'd0 || mem_readdata !== 32'h0) begin errors++; $display("FAIL reset_ret got id=%0d data=%0h exp 0 0", mem_readdataid, mem_readdata); end
    rst = 1'b0;
    #1;
    checks++; if (mem_waitrequest !== 1'b0) begin errors++; $display("FAIL release_wait got=%0b exp=0", mem_waitrequest); end
  endtask

  task automatic test_single_write;
    mem_write = 1'b1; mem_address = 30'h10; mem_writedata = 32'hDEADBEEF; mem_writedatamask = 4'b0101; mem_id = 2'd1;
    #1;
    checks++; if (mem_waitrequest !== 1'b0) begin errors++; $display("FAIL write_wait got=%0b exp=0", mem_waitrequest); end
    tick;
    mem_write = 1'b0;
    checks++; if (sram_wr !== 1'b1 || sram_rd !== 1'b0) begin errors++; $display("FAIL write_strobe got wr=%0b rd=%0b exp 1 0", sram_wr, sram_rd); end
    checks++; if (sram_addr !== 30'h10 || sram_be !== 4'b0101 || sram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_fields got addr=%0h be=%0b data=%0h exp 10 0101 deadbeef", sram_addr, sram_be, sram_wdata); end
    checks++; if (mem_waitrequest !== 1'b0) begin errors++; $display("FAIL write_wait_after got=%0b exp=0", mem_waitrequest); end
    tick;
    checks++; if (sram_wr !== 1'b0) begin errors++; $display("FAIL write_single got=%0b exp=0", sram_wr); end
  endtask

  task automatic test_wrapped_burst;
    logic [29:0] a;
    logic [1:0] eid;
    mem_read = 1'b1; mem_address = 30'h6; mem_id = 2'd2;
    tick;
    mem_read = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++; if (mem_waitrequest !== (k <= 4)) begin errors++; $display("FAIL burst_wait k=%0d got=%0b exp=%0b", k, mem_waitrequest, (k <= 4)); end
      if (k <= 4) begin
        a = 30'h4 | 30'((k + 1) & 3);
        checks++; if (sram_rd !== 1'b1 || sram_addr !== a) begin errors++; $display("FAIL burst_issue k=%0d got rd=%0b addr=%0h exp 1 %0h", k, sram_rd, sram_addr, a); end
      end
      eid = (k >= 4 && k <= 7) ? 2'd2 : 2'd0;
      checks++; if (mem_readdataid !== eid) begin errors++; $display("FAIL burst_id k=%0d got=%0d exp=%0d", k, mem_readdataid, eid); end
      if (eid != 2'd0) begin
        a = 30'h4 | 30'((k - 2) & 3);
        checks++; if (mem_readdata !== (32'hA5000000 | 32'(a))) begin errors++; $display("FAIL burst_data k=%0d got=%0h exp=%0h", k, mem_readdata, 32'hA5000000 | 32'(a)); end
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] eid;
    logic [31:0] ed;
    mem_read = 1'b1; mem_address = 30'h100; mem_id = 2'd1;
    tick;
    mem_address = 30'h200; mem_id = 2'd2;
    for (int k = 1; k <= 13; k++) begin
      checks++; if (mem_waitrequest !== (k <= 4 || (k >= 6 && k <= 9))) begin errors++; $display("FAIL b2b_wait k=%0d got=%0b", k, mem_waitrequest); end
      eid = (k >= 4 && k <= 7) ? 2'd1 : (k >= 9 && k <= 12) ? 2'd2 : 2'd0;
      ed = (k <= 7) ? 32'hA5000100 + 32'(k - 4) : 32'hA5000200 + 32'(k - 9);
      checks++; if (mem_readdataid !== eid) begin errors++; $display("FAIL b2b_id k=%0d got=%0d exp=%0d", k, mem_readdataid, eid); end
      if (eid != 2'd0) begin
        checks++; if (mem_readdata !== ed) begin errors++; $display("FAIL b2b_data k=%0d got=%0h exp=%0h", k, mem_readdata, ed); end
      end
      tick;
      if (k == 5) mem_read = 1'b0;
    end
  endtask

  task automatic test_write_behind_read;
    logic [31:0] ed;
    mem_read = 1'b1; mem_address = 30'h40; mem_id = 2'd1;
    tick;
    mem_read = 1'b0; mem_write = 1'b1; mem_writedata = 32'h22222222; mem_writedatamask = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      checks++; if (mem_waitrequest !== (k <= 4)) begin errors++; $display("FAIL wbr_wait k=%0d got=%0b", k, mem_waitrequest); end
      if (k >= 4) begin
        ed = (k == 4) ? 32'h11111111 : 32'hA5000040 + 32'(k - 4);
        checks++; if (mem_readdataid !== 2'd1 || mem_readdata !== ed) begin errors++; $display("FAIL wbr_data k=%0d got id=%0d data=%0h exp 1 %0h", k, mem_readdataid, mem_readdata, ed); end
      end
      if (k == 6) begin
        checks++; if (sram_wr !== 1'b1 || sram_addr !== 30'h40) begin errors++; $display("FAIL wbr_write got wr=%0b addr=%0h exp 1 40", sram_wr, sram_addr); end
      end
      tick;
      if (k == 5) mem_write = 1'b0;
    end
    mem_read = 1'b1; mem_address = 30'h40; mem_id = 2'd1;
    tick;
    mem_read = 1'b0;
    repeat (3) tick;
    checks++; if (mem_readdataid !== 2'd1 || mem_readdata !== 32'h22222222) begin errors++; $display("FAIL wbr_reread got id=%0d data=%0h exp 1 22222222", mem_readdataid, mem_readdata); end
    repeat (6) tick;
  endtask

  task automatic test_reset_mid_burst;
    mem_read = 1'b1; mem_address = 30'h80; mem_id = 2'd2;
    tick;
    mem_read = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    checks++; if (mem_waitrequest !== 1'b1) begin errors++; $display("FAIL rstmid_wait got=%0b exp=1", mem_waitrequest); end
    tick;
    rst = 1'b0;
    #1;
    checks++; if (mem_waitrequest !== 1'b0) begin errors++; $display("FAIL rstmid_release got=%0b exp=0", mem_waitrequest); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (mem_readdataid !== 2'd0 || sram_rd !== 1'b0) begin errors++; $display("FAIL rstmid_quiet k=%0d got id=%0d rd=%0b exp 0 0", k, mem_readdataid, sram_rd); end
      tick;
    end
  endtask

  task automatic test_param_sweep;
    logic [1:0] eid;
    logic [31:0] ed;
    s_read = 1'b1; s_addr = 30'h35; s_id = 2'd1;
    tick;
    s_read = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      checks++; if (a_wait !== (k == 1)) begin errors++; $display("FAIL sweep_a_wait k=%0d got=%0b", k, a_wait); end
      eid = (k == 3) ? 2'd1 : 2'd0;
      checks++; if (a_id !== eid) begin errors++; $display("FAIL sweep_a_id k=%0d got=%0d exp=%0d", k, a_id, eid); end
      if (k == 3) begin
        checks++; if (a_data !== 32'h35) begin errors++; $display("FAIL sweep_a_data got=%0h exp=35", a_data); end
      end
      checks++; if (b_wait !== (k <= 8)) begin errors++; $display("FAIL sweep_b_wait k=%0d got=%0b", k, b_wait); end
      eid = (k >= 10 && k <= 17) ? 2'd1 : 2'd0;
      checks++; if (b_id !== eid) begin errors++; $display("FAIL sweep_b_id k=%0d got=%0d exp=%0d", k, b_id, eid); end
      if (eid != 2'd0) begin
        ed = 32'h30 | 32'((k - 5) & 7);
        checks++; if (b_data !== ed) begin errors++; $display("FAIL sweep_b_data k=%0d got=%0h exp=%0h", k, b_data, ed); end
      end
      tick;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_id = 2'd0; mem_address = '0;
    mem_writedata = '0; mem_writedatamask = '0; s_read = 1'b0; s_id = 2'd0; s_addr = '0;
    test_reset;
    test_single_write;
    test_wrapped_burst;
    test_back_to_back;
    test_write_behind_read;
    test_reset_mid_burst;
    test_param_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
